quad_encoder_counter: RTL

Multi-channel quadrature encoder front end for the panel UI: synchronises and debounces NUM_CH A/B encoder pairs, decodes every Gray-code transition, groups sub-steps into detents and maintains a bounded per-channel position register. Emits per-detent inc/dec pulses and illegal-transition flags. Sits between the board encoder pins and the menu/LCD control logic, replacing single-pulse-only decoding.

---
 rtl/quad_encoder_if.sv | 10 +
 rtl/quad_encoder_counter.sv | 112 +++++++++++
 2 files changed

// File: rtl/quad_encoder_if.sv
// quad_encoder_if: encoder pins, per-channel clear and detent/position outputs
interface quad_encoder_if #(
  parameter int NUM_CH = 2,
  parameter int COUNT_W = 16
);
  logic [NUM_CH-1:0] enc_a, enc_b, clr, inc_pulse, dec_pulse, err_pulse;
  logic [NUM_CH*COUNT_W-1:0] position;
  modport master (output enc_a, enc_b, clr, input inc_pulse, dec_pulse, err_pulse, position);
  modport slave (input enc_a, enc_b, clr, output inc_pulse, dec_pulse, err_pulse, position);
endinterface

// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter: debounced multi-channel quadrature decoder with detent pulses and bounded position
// Define QENC_ACCEL_EN to enable per-channel acceleration of the position step
module quad_encoder_counter #(
  parameter int NUM_CH = 2,
  parameter int DEBOUNCE_TIME = 1000,
  parameter int STEPS_PER_DETENT = 4,
  parameter int COUNT_W = 16,
  parameter int MAX_COUNT = 255,
  parameter int WRAP = 0,
  parameter int ACCEL_WINDOW = 2000000,
  parameter int ACCEL_STEP = 4
) (
  input logic clk,
  input logic rst_n,
  quad_encoder_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_TIME + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_TIME);
  localparam logic signed [3:0] SPD = 4'(STEPS_PER_DETENT);
  localparam logic [COUNT_W:0] MAX_X = (COUNT_W+1)'(MAX_COUNT);
  localparam logic [COUNT_W:0] MOD = MAX_X + 1'b1;
  localparam logic [COUNT_W:0] ONE = (COUNT_W+1)'(1);
`ifdef QENC_ACCEL_EN
  localparam int TW = $clog2(ACCEL_WINDOW + 1);
  localparam logic [TW-1:0] T_MAX = TW'(ACCEL_WINDOW);
  localparam logic [COUNT_W:0] ACC_X = (COUNT_W+1)'(ACCEL_STEP);
`endif
  if (NUM_CH < 1 || NUM_CH > 8 || DEBOUNCE_TIME < 2 ||
      (STEPS_PER_DETENT != 1 && STEPS_PER_DETENT != 2 && STEPS_PER_DETENT != 4) ||
      MAX_COUNT < 1 || longint'(MAX_COUNT) >= (longint'(1) << COUNT_W) ||
      ACCEL_STEP < 1 || ACCEL_STEP > MAX_COUNT || ACCEL_WINDOW < 1) begin : g_cfg_err
    $error("quad_encoder_counter: invalid parameter set");
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0] s1, s2, st, pv, ph_n, ph_o, dlt;
    logic [DW-1:0] cnt [2];
    logic signed [3:0] acc, acc_n;
    logic [COUNT_W-1:0] pos, pos_inc, pos_dec;
    logic [COUNT_W:0] up, step;
    logic fwd, rev, bad, hit_inc, hit_dec, inc_q, dec_q, err_q;
`ifdef QENC_ACCEL_EN
    logic [TW-1:0] tmr;
    logic last_up;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        tmr <= T_MAX;
        last_up <= 1'b0;
      end else if (bus.clr[i]) begin
        tmr <= T_MAX;
      end else if (hit_inc || hit_dec) begin
        tmr <= '0;
        last_up <= hit_inc;
      end else if (tmr != T_MAX) begin
        tmr <= tmr + 1'b1;
      end
`endif
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s1 <= 2'b11;
        s2 <= 2'b11;
        st <= 2'b11;
        pv <= 2'b11;
        cnt <= '{default: '0};
      end else begin
        s1 <= {bus.enc_a[i], bus.enc_b[i]};
        s2 <= s1;
        pv <= st;
        for (int k = 0; k < 2; k++) begin
          cnt[k] <= (s2[k] == st[k] || cnt[k] == DB_MAX) ? '0 : cnt[k] + 1'b1;
          if (s2[k] != st[k] && cnt[k] == DB_MAX) st[k] <= s2[k];
        end
      end
    always_comb begin
      ph_n = {~st[0], st[1] ^ st[0]};
      ph_o = {~pv[0], pv[1] ^ pv[0]};
      dlt = ph_n - ph_o;
      fwd = dlt == 2'd1;
      rev = dlt == 2'd3;
      bad = dlt == 2'd2;
      acc_n = acc + (fwd ? 4'sd1 : rev ? -4'sd1 : 4'sd0);
      hit_inc = acc_n == SPD;
      hit_dec = acc_n == -SPD;
`ifdef QENC_ACCEL_EN
      step = (tmr < T_MAX && hit_inc == last_up) ? ACC_X : ONE;
`else
      step = ONE;
`endif
      up = {1'b0, pos} + step;
      pos_inc = COUNT_W'(WRAP != 0 ? (up >= MOD ? up - MOD : up) : (up > MAX_X ? MAX_X : up));
      pos_dec = COUNT_W'({1'b0, pos} >= step ? {1'b0, pos} - step :
                         WRAP != 0 ? MOD - (step - {1'b0, pos}) : '0);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        acc <= '0;
        pos <= '0;
        inc_q <= 1'b0;
        dec_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        inc_q <= hit_inc & ~bus.clr[i];
        dec_q <= hit_dec & ~bus.clr[i];
        err_q <= bad;
        acc <= (bus.clr[i] || hit_inc || hit_dec) ? '0 : acc_n;
        pos <= bus.clr[i] ? '0 : hit_inc ? pos_inc : hit_dec ? pos_dec : pos;
      end
    assign bus.inc_pulse[i] = inc_q;
    assign bus.dec_pulse[i] = dec_q;
    assign bus.err_pulse[i] = err_q;
    assign bus.position[i*COUNT_W +: COUNT_W] = pos;
  end
endmodule
